// File: rtl/dcache_arb_pkg.sv
// Shared types for the data-cache port arbiter: FSM state encoding and the
// request bundle that is driven onto the cache port or parked in the hold buffer.
package dcache_arb_pkg;

  localparam int ARB_LINE_OFFSET_BITS = 5;
  localparam int ARB_PF_TIMEOUT       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEM  = 2'd1,
    PF   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } cache_req_t;

endpackage

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single dcache UFP port between execute demands and stride-prefetch line fetches.
// Optional build macro DCACHE_ARB_PF_DEDUP_EN drops prefetches that hit the line of the last demand.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int PF_TIMEOUT = ARB_PF_TIMEOUT
`ifdef DCACHE_ARB_PF_DEDUP_EN
  ,
  parameter int LINE_OFFSET_BITS = ARB_LINE_OFFSET_BITS
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_ack,
  output logic        pf_done,
  output logic        pf_drop,
  output logic [31:0] ufp_addr,
  output logic [3:0]  ufp_rmask,
  output logic [3:0]  ufp_wmask,
  output logic [31:0] ufp_wdata,
  input  logic [31:0] ufp_rdata,
  input  logic        ufp_resp,
  output logic        busy,
  output arb_state_t  dbg_state
);

  localparam int TO_W = $clog2(PF_TIMEOUT + 1);

  // Handshake: a nonzero rmask/wmask is a one-cycle request; the matching
  // *_resp pulse completes it. pf_req is level, held until pf_ack or pf_drop.
  arb_state_t      state_q, state_d;
  cache_req_t      dem_req, ufp_req;
  cache_req_t      buf_q;
  logic            buf_valid_q;
  logic            buf_set, buf_clr;
  logic            demand_live, dem_issue;
  logic            pf_dup, dedup_drop, timeout_hit;
  logic [TO_W-1:0] to_cnt_q;
  logic            pf_addr_unused;

  assign demand_live    = (|dmem_rmask) | (|dmem_wmask);
  assign dem_req        = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
  assign pf_addr_unused = ^pf_addr[1:0];

`ifdef DCACHE_ARB_PF_DEDUP_EN
  logic [31-LINE_OFFSET_BITS:0] last_line_q;
  logic                         last_line_valid_q;

  assign pf_dup = last_line_valid_q && (pf_addr[31:LINE_OFFSET_BITS] == last_line_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_line_q       <= '0;
      last_line_valid_q <= 1'b0;
    end else if (dem_issue) begin
      last_line_q       <= ufp_req.addr[31:LINE_OFFSET_BITS];
      last_line_valid_q <= 1'b1;
    end
  end
`else
  assign pf_dup = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ufp_req    = '0;
    dmem_rdata = '0;
    dmem_resp  = 1'b0;
    pf_ack     = 1'b0;
    pf_done    = 1'b0;
    dedup_drop = 1'b0;
    buf_set    = 1'b0;
    buf_clr    = 1'b0;
    dem_issue  = 1'b0;
    // Outputs are held low while reset is asserted; the cache resets alongside.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (demand_live) begin
            ufp_req   = dem_req;
            dem_issue = 1'b1;
            state_d   = DEM;
          end else if (buf_valid_q) begin
            ufp_req   = buf_q;
            buf_clr   = 1'b1;
            dem_issue = 1'b1;
            state_d   = DEM;
          end else if (pf_req && pf_dup) begin
            dedup_drop = 1'b1;
          end else if (pf_req) begin
            ufp_req.addr  = {pf_addr[31:2], 2'b00};
            ufp_req.rmask = 4'hF;
            pf_ack        = 1'b1;
            state_d       = PF;
          end
        end
        DEM: begin
          dmem_rdata = ufp_rdata;
          dmem_resp  = ufp_resp;
          if (ufp_resp) state_d = IDLE;
        end
        PF: begin
          // A demand landing on the fill-completion cycle is still parked.
          if (demand_live) buf_set = 1'b1;
          if (ufp_resp) begin
            pf_done = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign timeout_hit = pf_req && !pf_ack && (to_cnt_q == TO_W'(PF_TIMEOUT));
  assign pf_drop     = !rst && (timeout_hit || dedup_drop);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
    end else if (buf_set) begin
      buf_valid_q <= 1'b1;
      buf_q       <= dem_req;
    end else if (buf_clr) begin
      buf_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !pf_req || pf_ack || pf_drop) to_cnt_q <= '0;
    else                                     to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign ufp_addr  = ufp_req.addr;
  assign ufp_rmask = ufp_req.rmask;
  assign ufp_wmask = ufp_req.wmask;
  assign ufp_wdata = ufp_req.wdata;
  assign busy      = !rst && (state_q != IDLE);
  assign dbg_state = state_q;

  // Execute waits for dmem_resp before issuing again, so no demand may arrive in DEM.
  assert property (@(posedge clk) disable iff (rst) (state_q == DEM) |-> !demand_live);
  assert property (@(posedge clk) disable iff (rst) !(pf_ack && pf_drop));
  assert property (@(posedge clk) disable iff (rst) !(dmem_resp && pf_done));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: stimulus pushes cycle-stamped expected events,
// a negedge monitor pops and compares every event the DUT presents.
module tb_dcache_port_arbiter;
  import dcache_arb_pkg::*;

  localparam int W = 91;
  localparam logic [2:0] K_UFP   = 3'd1;
  localparam logic [2:0] K_DRESP = 3'd2;
  localparam logic [2:0] K_ACK   = 3'd3;
  localparam logic [2:0] K_DONE  = 3'd4;
  localparam logic [2:0] K_DROP  = 3'd5;

  logic        clk, rst;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic        dmem_resp;
  logic        pf_req, pf_ack, pf_done, pf_drop;
  logic [31:0] pf_addr;
  logic [31:0] ufp_addr, ufp_wdata, ufp_rdata;
  logic [3:0]  ufp_rmask, ufp_wmask;
  logic        ufp_resp, busy;
  arb_state_t  dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int unsigned  cyc = 0;

  dcache_port_arbiter dut (
    .clk(clk), .rst(rst),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_ack(pf_ack), .pf_done(pf_done), .pf_drop(pf_drop),
    .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask), .ufp_wdata(ufp_wdata),
    .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ev(input logic [2:0] k, input int unsigned c,
                                      input logic [31:0] a, input logic [7:0] m,
                                      input logic [31:0] d);
    logic [15:0] c16;
    c16 = c[15:0];
    return {k, c16, a, m, d};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] k, input logic [31:0] a, input logic [7:0] m,
                      input logic [31:0] d);
    exp_q.push_back(ev(k, cyc, a, m, d));
  endtask

  task automatic idle_inputs();
    dmem_addr  = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
    pf_req     = 1'b0;
    pf_addr    = '0;
    ufp_rdata  = '0;
    ufp_resp   = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // scoreboard
  task automatic sb(input string name, input logic [W-1:0] got);
    logic [W-1:0] want;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got unexpected event %h at cycle %0d, want none", name, got, cyc);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_err++;
        $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if ((ufp_rmask != 4'h0) || (ufp_wmask != 4'h0))
      sb("ufp_req", ev(K_UFP, cyc, ufp_addr, {ufp_rmask, ufp_wmask}, ufp_wdata));
    if (dmem_resp) sb("dmem_resp", ev(K_DRESP, cyc, 32'h0, 8'h0, dmem_rdata));
    if (pf_ack)    sb("pf_ack",    ev(K_ACK,   cyc, 32'h0, 8'h0, 32'h0));
    if (pf_done)   sb("pf_done",   ev(K_DONE,  cyc, 32'h0, 8'h0, 32'h0));
    if (pf_drop)   sb("pf_drop",   ev(K_DROP,  cyc, 32'h0, 8'h0, 32'h0));
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_state", {30'h0, dbg_state}, {30'h0, IDLE});
    chk("reset_ufp_rmask", {28'h0, ufp_rmask}, 32'h0);
    chk("reset_outs", {28'h0, dmem_resp, pf_ack, pf_done, pf_drop}, 32'h0);
    tick();

    // demand read, cache answers three cycles after issue
    dmem_addr = 32'h1000; dmem_rmask = 4'hF;
    push(K_UFP, 32'h1000, 8'hF0, 32'h0);
    chk("s1_busy_issue", {31'h0, busy}, 32'h0);
    tick(); dmem_rmask = 4'h0; dmem_addr = 32'h0;
    chk("s1_busy_1", {31'h0, busy}, 32'h1);
    tick();
    chk("s1_busy_2", {31'h0, busy}, 32'h1);
    tick(); ufp_resp = 1'b1; ufp_rdata = 32'hDEADBEEF;
    push(K_DRESP, 32'h0, 8'h0, 32'hDEADBEEF);
    tick(); ufp_resp = 1'b0; ufp_rdata = 32'h0;
    chk("s1_busy_after", {31'h0, busy}, 32'h0);

    // prefetch in idle
    tick(); pf_req = 1'b1; pf_addr = 32'h2044;
    push(K_UFP, 32'h2044, 8'hF0, 32'h0);
    push(K_ACK, 32'h0, 8'h0, 32'h0);
    tick(); pf_req = 1'b0;
    chk("s2_state_pf", {30'h0, dbg_state}, {30'h0, PF});
    tick(); ufp_resp = 1'b1; ufp_rdata = 32'h11112222;
    push(K_DONE, 32'h0, 8'h0, 32'h0);
    tick(); ufp_resp = 1'b0; ufp_rdata = 32'h0;

    // demand write parked behind an unaligned prefetch
    tick(); pf_req = 1'b1; pf_addr = 32'h2103;
    push(K_UFP, 32'h2100, 8'hF0, 32'h0);
    push(K_ACK, 32'h0, 8'h0, 32'h0);
    tick(); pf_req = 1'b0;
    dmem_addr = 32'h3000; dmem_wmask = 4'h3; dmem_wdata = 32'h55;
    tick(); dmem_addr = 32'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    chk("s3_busy_pf", {31'h0, busy}, 32'h1);
    tick(); ufp_resp = 1'b1;
    push(K_DONE, 32'h0, 8'h0, 32'h0);
    tick(); ufp_resp = 1'b0;
    push(K_UFP, 32'h3000, 8'h03, 32'h55);
    tick();
    chk("s3_state_dem", {30'h0, dbg_state}, {30'h0, DEM});
    tick(); ufp_resp = 1'b1;
    push(K_DRESP, 32'h0, 8'h0, 32'h0);
    tick(); ufp_resp = 1'b0;

    // demand arriving on the prefetch completion cycle
    tick(); pf_req = 1'b1; pf_addr = 32'h2200;
    push(K_UFP, 32'h2200, 8'hF0, 32'h0);
    push(K_ACK, 32'h0, 8'h0, 32'h0);
    tick(); pf_req = 1'b0;
    tick(); ufp_resp = 1'b1; dmem_addr = 32'h3104; dmem_rmask = 4'h1;
    push(K_DONE, 32'h0, 8'h0, 32'h0);
    tick(); ufp_resp = 1'b0; dmem_addr = 32'h0; dmem_rmask = 4'h0;
    push(K_UFP, 32'h3104, 8'h10, 32'h0);
    tick(); ufp_resp = 1'b1; ufp_rdata = 32'hAB;
    push(K_DRESP, 32'h0, 8'h0, 32'hAB);
    tick(); ufp_resp = 1'b0; ufp_rdata = 32'h0;

    // timeout: back-to-back demands starve a held pf_req for 16 cycles
    tick(); pf_req = 1'b1; pf_addr = 32'h8000;
    for (int k = 0; k <= 16; k++) begin
      if ((k % 2) == 0) begin
        ufp_resp = 1'b0; dmem_addr = 32'h5000 + 32'(4 * k); dmem_rmask = 4'hF;
        push(K_UFP, 32'h5000 + 32'(4 * k), 8'hF0, 32'h0);
      end else begin
        dmem_rmask = 4'h0; ufp_resp = 1'b1; ufp_rdata = 32'h5000 + 32'(k);
        push(K_DRESP, 32'h0, 8'h0, 32'h5000 + 32'(k));
      end
      if (k == 16) push(K_DROP, 32'h0, 8'h0, 32'h0);
      tick();
    end
    pf_req = 1'b0; dmem_rmask = 4'h0; dmem_addr = 32'h0;
    ufp_resp = 1'b1; ufp_rdata = 32'h5011;
    push(K_DRESP, 32'h0, 8'h0, 32'h5011);
    tick(); ufp_resp = 1'b0; ufp_rdata = 32'h0;

    // prefetch to the line of the last demand, then to the next line
    tick(); dmem_addr = 32'h4008; dmem_rmask = 4'hF;
    push(K_UFP, 32'h4008, 8'hF0, 32'h0);
    tick(); dmem_addr = 32'h0; dmem_rmask = 4'h0; ufp_resp = 1'b1; ufp_rdata = 32'h4;
    push(K_DRESP, 32'h0, 8'h0, 32'h4);
    tick(); ufp_resp = 1'b0; ufp_rdata = 32'h0; pf_req = 1'b1; pf_addr = 32'h401C;
`ifdef DCACHE_ARB_PF_DEDUP_EN
    push(K_DROP, 32'h0, 8'h0, 32'h0);
    tick(); pf_req = 1'b0;
`else
    push(K_UFP, 32'h401C, 8'hF0, 32'h0);
    push(K_ACK, 32'h0, 8'h0, 32'h0);
    tick(); pf_req = 1'b0;
    tick(); ufp_resp = 1'b1;
    push(K_DONE, 32'h0, 8'h0, 32'h0);
    tick(); ufp_resp = 1'b0;
`endif
    tick(); pf_req = 1'b1; pf_addr = 32'h4020;
    push(K_UFP, 32'h4020, 8'hF0, 32'h0);
    push(K_ACK, 32'h0, 8'h0, 32'h0);
    tick(); pf_req = 1'b0;
    tick(); ufp_resp = 1'b1;
    push(K_DONE, 32'h0, 8'h0, 32'h0);
    tick(); ufp_resp = 1'b0;

    // reset while a prefetch is outstanding with a parked demand
    tick(); pf_req = 1'b1; pf_addr = 32'h6000;
    push(K_UFP, 32'h6000, 8'hF0, 32'h0);
    push(K_ACK, 32'h0, 8'h0, 32'h0);
    tick(); pf_req = 1'b0;
    dmem_addr = 32'h6100; dmem_wmask = 4'hF; dmem_wdata = 32'hA5A5A5A5;
    tick(); dmem_addr = 32'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0; rst = 1'b1;
    tick(); rst = 1'b0;
    chk("s6_busy", {31'h0, busy}, 32'h0);
    chk("s6_state", {30'h0, dbg_state}, {30'h0, IDLE});
    chk("s6_ufp_addr", ufp_addr, 32'h0);
    chk("s6_buffer_empty", {28'h0, ufp_wmask}, 32'h0);
    tick();
    chk("s6_no_late_issue", {28'h0, ufp_wmask}, 32'h0);
    tick(); dmem_addr = 32'h7000; dmem_rmask = 4'hF;
    push(K_UFP, 32'h7000, 8'hF0, 32'h0);
    tick(); dmem_addr = 32'h0; dmem_rmask = 4'h0; ufp_resp = 1'b1; ufp_rdata = 32'hCAFEF00D;
    push(K_DRESP, 32'h0, 8'h0, 32'hCAFEF00D);
    tick(); ufp_resp = 1'b0; ufp_rdata = 32'h0;
    repeat (3) tick();

    // final report
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_event: got nothing want %h", exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
